// File: rtl/seq_ser_pkg.sv
// Shared types and constants for the serial word feeder.
package seq_ser_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
endpackage

// File: rtl/seq_serializer_if.sv
// Parallel-in handshake and serial-out bundle between upstream, serializer and detector.
interface seq_serializer_if
  import seq_ser_pkg::*;
  #(parameter int WIDTH = DEFAULT_WIDTH);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_start;
  logic             busy;
  logic [1:0]       state_out;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, word_start, busy, state_out
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, word_start, busy, state_out
  );
endinterface

// File: rtl/seq_ser_hold_reg.sv
// Single-entry valid/ready holding buffer; ready depends only on occupancy and reset.
module seq_ser_hold_reg
  import seq_ser_pkg::*;
  #(parameter int WIDTH = DEFAULT_WIDTH)
  (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic             pop,
    output logic             hold_full,
    output logic [WIDTH-1:0] hold_data
  );

  logic push;

  assign push_ready = !hold_full && !rst;
  assign push       = push_valid && push_ready;

  // push needs an empty slot and pop needs a full one, so they never coincide
  always_ff @(posedge clk) begin
    if (rst)       hold_full <= 1'b0;
    else if (push) hold_full <= 1'b1;
    else if (pop)  hold_full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) hold_data <= push_data;
  end
endmodule

// File: rtl/seq_serializer.sv
// MSB-first word serializer feeding the sequence detector.
// Optional even-parity bit after each word when SEQ_SER_PARITY_EN is defined.
module seq_serializer
  import seq_ser_pkg::*;
  #(
    parameter int   WIDTH    = DEFAULT_WIDTH,
    parameter logic IDLE_BIT = 1'b0
  )
  (
    input  logic             clk,
    input  logic             rst,
    seq_serializer_if.slave  bus
  );

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] hold_data;
  logic [CNT_W-1:0] bit_cnt;
  logic             hold_full;
  logic             load;
  logic             ser_out_c;
  logic             ser_valid_c;

  seq_ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .push_data  (bus.in_data),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .pop        (load),
    .hold_full  (hold_full),
    .hold_data  (hold_data)
  );

`ifdef SEQ_SER_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (load) par_bit <= ^hold_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                                 bit_cnt <= '0;
    else if (load)                           bit_cnt <= CNT_TOP;
    else if (state == SHIFT && bit_cnt != 0) bit_cnt <= bit_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (load)                shift_reg <= hold_data;
    else if (state == SHIFT) shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
  end

  // load doubles as the buffer pop, so a reload and a new accept never share an edge
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    ser_out_c   = IDLE_BIT;
    ser_valid_c = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        ser_out_c   = shift_reg[WIDTH-1];
        ser_valid_c = 1'b1;
        if (bit_cnt == 0) begin
`ifdef SEQ_SER_PARITY_EN
          state_nxt = PARITY;
`else
          load      = hold_full;
          state_nxt = hold_full ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SEQ_SER_PARITY_EN
      PARITY: begin
        ser_out_c   = par_bit;
        ser_valid_c = 1'b1;
        load        = hold_full;
        state_nxt   = hold_full ? SHIFT : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ser_out    = ser_out_c;
  assign bus.ser_valid  = ser_valid_c;
  assign bus.word_start = (state == SHIFT) && (bit_cnt == CNT_TOP);
  assign bus.busy       = hold_full || (state != IDLE);
  assign bus.state_out  = state;
endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: vector table, directed multi-cycle sequences, random scoreboard.
module tb_seq_serializer;
  import seq_ser_pkg::*;

  localparam int W = 8;
`ifdef SEQ_SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk;
  logic rst;

  seq_serializer_if #(.WIDTH(W)) bus ();

  seq_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       r;
    logic       vld;
    logic [7:0] data;
    logic       e_out;
    logic       e_vld;
    logic       e_ws;
    logic       e_busy;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add_word(input logic [7:0] w);
    vec_t v;
    v = '{r:1'b0, vld:1'b1, data:w, e_out:1'b0, e_vld:1'b0, e_ws:1'b0, e_busy:1'b1, e_rdy:1'b0};
    vecs.push_back(v);
    for (int i = W - 1; i >= 0; i--) begin
      v = '{r:1'b0, vld:1'b0, data:8'h00, e_out:w[i], e_vld:1'b1, e_ws:(i == W - 1),
            e_busy:1'b1, e_rdy:1'b1};
      vecs.push_back(v);
    end
    if (P == 1) begin
      v = '{r:1'b0, vld:1'b0, data:8'h00, e_out:^w, e_vld:1'b1, e_ws:1'b0, e_busy:1'b1, e_rdy:1'b1};
      vecs.push_back(v);
    end
    v = '{r:1'b0, vld:1'b0, data:8'h00, e_out:1'b0, e_vld:1'b0, e_ws:1'b0, e_busy:1'b0, e_rdy:1'b1};
    vecs.push_back(v);
  endtask

  // Directed stream driver: offers queued words, records outputs after each edge
  logic [7:0] words_q[$];
  logic       rec_out[$];
  logic       rec_vld[$];
  logic       rec_rdy[$];

  task automatic run_words(input int ncyc);
    int  idx;
    logic acc;
    idx = 0;
    rec_out.delete(); rec_vld.delete(); rec_rdy.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (idx < words_q.size()) begin
        bus.in_valid = 1'b1;
        bus.in_data  = words_q[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      rec_out.push_back(bus.ser_out);
      rec_vld.push_back(bus.ser_valid);
      rec_rdy.push_back(bus.in_ready);
    end
    bus.in_valid = 1'b0;
  endtask

  typedef struct {
    logic b;
    logic first;
  } sbit_t;

  sbit_t model_q[$];

  task automatic model_push(input logic [7:0] w);
    sbit_t s;
    for (int i = W - 1; i >= 0; i--) begin
      s.b = w[i];
      s.first = (i == W - 1);
      model_q.push_back(s);
    end
    if (P == 1) begin
      s.b = ^w;
      s.first = 1'b0;
      model_q.push_back(s);
    end
  endtask

  task automatic model_cycle(input logic acc, input logic [7:0] w);
    sbit_t s;
    @(posedge clk); #1;
    if (acc) model_push(w);
    check("rnd_busy", bus.busy, model_q.size() != 0);
    if (bus.ser_valid) begin
      if (model_q.size() == 0) begin
        check("rnd_extra_bit", 1, 0);
      end else begin
        s = model_q.pop_front();
        check("rnd_bit", bus.ser_out, s.b);
        check("rnd_word_start", bus.word_start, s.first);
      end
    end else begin
      check("rnd_idle_out", {bus.ser_out, bus.word_start}, 2'b00);
    end
  endtask

  initial begin
    int   wb;
    logic acc;
    logic [7:0] w;
    logic bits[$];
    int   hits[$];
    int   nv;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    for (int i = 0; i < 3; i++)
      vecs.push_back('{r:1'b1, vld:1'b0, data:8'h00, e_out:1'b0, e_vld:1'b0, e_ws:1'b0,
                       e_busy:1'b0, e_rdy:1'b0});
    vecs.push_back('{r:1'b0, vld:1'b0, data:8'h00, e_out:1'b0, e_vld:1'b0, e_ws:1'b0,
                     e_busy:1'b0, e_rdy:1'b1});
    add_word(8'hA5);
    add_word(8'h07);

    // Table: reset state, single words with latency, word_start and parity
    for (int k = 0; k < vecs.size(); k++) begin
      rst          = vecs[k].r;
      bus.in_valid = vecs[k].vld;
      bus.in_data  = vecs[k].data;
      @(posedge clk); #1;
      check($sformatf("vec%0d_ser_out", k), bus.ser_out, vecs[k].e_out);
      check($sformatf("vec%0d_ser_valid", k), bus.ser_valid, vecs[k].e_vld);
      check($sformatf("vec%0d_word_start", k), bus.word_start, vecs[k].e_ws);
      check($sformatf("vec%0d_busy", k), bus.busy, vecs[k].e_busy);
      check($sformatf("vec%0d_in_ready", k), bus.in_ready, vecs[k].e_rdy);
      if (!vecs[k].e_vld && !vecs[k].e_busy)
        check($sformatf("vec%0d_state", k), bus.state_out, 2'd0);
    end
    bus.in_valid = 1'b0;

    // Back-to-back words with in_valid held
    words_q = '{8'hA5, 8'h3C};
    wb = W + P;
    run_words(2 * wb + 3);
    check("b2b_rdy_after_accept1", rec_rdy[0], 1'b0);
    check("b2b_rdy_after_drain1", rec_rdy[1], 1'b1);
    check("b2b_rdy_after_accept2", rec_rdy[2], 1'b0);
    check("b2b_rdy_after_drain2", rec_rdy[wb + 1], 1'b1);
    nv = 0;
    for (int k = 1; k <= 2 * wb; k++) if (rec_vld[k]) nv++;
    check("b2b_contiguous_valid", nv, 2 * wb);
    for (int j = 0; j < 2; j++) begin
      w = words_q[j];
      for (int i = 0; i < W; i++)
        check($sformatf("b2b_w%0d_bit%0d", j, i), rec_out[1 + j * wb + i], w[W - 1 - i]);
      if (P == 1) check($sformatf("b2b_w%0d_parity", j), rec_out[1 + j * wb + W], ^w);
    end
    check("b2b_idle_after", rec_vld[2 * wb + 1], 1'b0);

    // Detector chain: 10101000 should match 101 on the 3rd and 5th bits
    words_q = '{8'hA8};
    run_words(wb + 3);
    bits.delete();
    for (int k = 0; k < rec_vld.size(); k++) if (rec_vld[k]) bits.push_back(rec_out[k]);
    check("det_bit_count", bits.size(), wb);
    hits.delete();
    for (int j = 2; j < W && j < bits.size(); j++)
      if (bits[j - 2] == 1'b1 && bits[j - 1] == 1'b0 && bits[j] == 1'b1) hits.push_back(j + 1);
    check("det_hits", hits.size(), 2);
    if (hits.size() == 2) begin
      check("det_hit0_pos", hits[0], 3);
      check("det_hit1_pos", hits[1], 5);
    end

    // Reset mid-word with a second word buffered
    bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    check("mid_rdy_e0", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_data = 8'h81;
    @(posedge clk); #1;
    check("mid_rdy_e2", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("mid_buffered", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    check("mid_busy_before", bus.busy, 1'b1);
    check("mid_bit3", {bus.ser_valid, bus.ser_out}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_ser_valid", bus.ser_valid, 1'b0);
    check("mid_busy", bus.busy, 1'b0);
    check("mid_in_ready", bus.in_ready, 1'b0);
    check("mid_state", bus.state_out, 2'd0);
    check("mid_ser_out", bus.ser_out, 1'b0);
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus.ser_valid || bus.busy) nv++;
    end
    check("mid_no_resume", nv, 0);

    // Randomized traffic against the bit-queue model
    bus.in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(bus.in_valid && !bus.in_ready)) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = 8'($urandom);
      end
      acc = bus.in_valid && bus.in_ready;
      w   = bus.in_data;
      model_cycle(acc, w);
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 60 && (model_q.size() != 0 || bus.busy); c++)
      model_cycle(1'b0, 8'h00);
    check("rnd_drained", model_q.size(), 0);
    check("rnd_final_busy", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
